// File: rtl/if_pkg.sv
// Shared types and default widths for the input-feature fetch unit.
// Holds the fetch state encoding and the packed tile-configuration record.
package if_pkg;

   localparam int unsigned IF_ADDR_W = 16;
   localparam int unsigned IF_DATA_W = 64;
   localparam int unsigned IF_DIM_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN,
      DONE
   } fetch_state_e;

   typedef struct packed {
      logic [IF_ADDR_W-1:0] base;
      logic [IF_DIM_W-1:0]  width;
      logic [IF_DIM_W-1:0]  height;
      logic [IF_ADDR_W-1:0] pitch;
   } tile_cfg_t;

   function automatic logic is_zero_tile(input tile_cfg_t cfg);
      return (cfg.width == '0) || (cfg.height == '0);
   endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bundle of controller handshake, tile config, SRAM read port and feeder stream.
// slave is the fetch unit side; master is the surrounding controller/memory/feeder side.
interface if_fetch_unit_if
   import if_pkg::*;
#(
   parameter int unsigned ADDR_W = IF_ADDR_W,
   parameter int unsigned DATA_W = IF_DATA_W,
   parameter int unsigned DIM_W  = IF_DIM_W
) ();

   logic              if_read;
   logic              clr_if;
   logic              if_done;
   logic [ADDR_W-1:0] cfg_base;
   logic [DIM_W-1:0]  cfg_width;
   logic [DIM_W-1:0]  cfg_height;
   logic [ADDR_W-1:0] cfg_pitch;
   logic              mem_rd_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;

   modport slave (
      input  if_read, clr_if, cfg_base, cfg_width, cfg_height, cfg_pitch, mem_rdata, out_ready,
      output if_done, mem_rd_en, mem_addr, out_valid, out_data, out_last
   );

   modport master (
      output if_read, clr_if, cfg_base, cfg_width, cfg_height, cfg_pitch, mem_rdata, out_ready,
      input  if_done, mem_rd_en, mem_addr, out_valid, out_data, out_last
   );

endinterface

// File: rtl/if_skid_buf.sv
// Two-entry FIFO holding {last, data} beats returned from the feature SRAM.
// The parent guarantees via credits that it is never pushed while full.
module if_skid_buf
   import if_pkg::*;
#(
   parameter int unsigned WIDTH = IF_DATA_W + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the head is only consumed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   assert property (@(posedge clk) disable iff (rst || flush) !(push && !pop && count_q == 2'd2));
   assert property (@(posedge clk) disable iff (rst || flush) !(pop && count_q == 2'd0));

endmodule

// File: rtl/if_fetch_unit.sv
// Input-feature fetch responder: walks a row-major tile in feature SRAM and streams
// the words to the systolic-array feeder, absorbing stalls in a 2-entry skid buffer.
module if_fetch_unit
   import if_pkg::*;
#(
   parameter int unsigned ADDR_W = IF_ADDR_W,
   parameter int unsigned DATA_W = IF_DATA_W,
   parameter int unsigned DIM_W  = IF_DIM_W
) (
   input  logic          clk,
   input  logic          rst,
   if_fetch_unit_if.slave bus
);

   fetch_state_e      state_q;
   tile_cfg_t         cfg_in;
   logic [DIM_W-1:0]  width_q;
   logic [DIM_W-1:0]  height_q;
   logic [ADDR_W-1:0] pitch_q;
   logic [DIM_W-1:0]  col_q;
   logic [DIM_W-1:0]  row_q;
   logic [ADDR_W-1:0] row_base_q;
   logic              inflight_q;
   logic              inflight_last_q;
   logic              if_done_q;

   logic [1:0]        occ;
   logic [DATA_W:0]   skid_head;
   logic [DATA_W:0]   head;
   logic              credit;
   logic              issue;
   logic              row_end;
   logic              last_issue;
   logic              abort;
   logic              out_valid;
   logic              pop;
   logic              skid_pop;
   logic              push;

   assign cfg_in = '{base:   bus.cfg_base,
                     width:  bus.cfg_width,
                     height: bus.cfg_height,
                     pitch:  bus.cfg_pitch};

   // Buffered beats plus the read still in the SRAM pipe may never exceed two.
   assign credit     = (occ == 2'd0) || ((occ == 2'd1) && !inflight_q);
   assign issue      = (state_q == FETCH) && bus.if_read && credit;
   assign row_end    = (col_q == width_q - DIM_W'(1));
   assign last_issue = issue && row_end && (row_q == height_q - DIM_W'(1));
   assign abort      = !bus.if_read && ((state_q == FETCH) || (state_q == DRAIN));

   // An empty buffer passes the returning word straight through to the feeder.
   assign out_valid = (occ != 2'd0) || inflight_q;
   assign head      = (occ != 2'd0) ? skid_head : {inflight_last_q, bus.mem_rdata};
   assign pop       = out_valid && bus.out_ready;
   assign skid_pop  = pop && (occ != 2'd0);
   assign push      = inflight_q && !(pop && (occ == 2'd0));

   if_skid_buf #(
      .WIDTH (DATA_W + 1)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .push      (push),
      .pop       (skid_pop),
      .push_data ({inflight_last_q, bus.mem_rdata}),
      .head      (skid_head),
      .count     (occ)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         width_q         <= '0;
         height_q        <= '0;
         pitch_q         <= '0;
         col_q           <= '0;
         row_q           <= '0;
         row_base_q      <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         if_done_q       <= 1'b0;
      end else begin
         if_done_q       <= 1'b0;
         inflight_q      <= issue;
         inflight_last_q <= last_issue;
         case (state_q)
            IDLE: begin
               if (bus.if_read && bus.clr_if) begin
                  width_q    <= cfg_in.width;
                  height_q   <= cfg_in.height;
                  pitch_q    <= cfg_in.pitch;
                  col_q      <= '0;
                  row_q      <= '0;
                  row_base_q <= cfg_in.base;
                  if (is_zero_tile(cfg_in)) begin
                     state_q   <= DONE;
                     if_done_q <= 1'b1;
                  end else begin
                     state_q <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (issue) begin
                  if (row_end) begin
                     col_q      <= '0;
                     row_q      <= row_q + DIM_W'(1);
                     row_base_q <= row_base_q + pitch_q;
                  end else begin
                     col_q <= col_q + DIM_W'(1);
                  end
                  if (last_issue) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (pop && head[DATA_W]) begin
                  state_q   <= DONE;
                  if_done_q <= 1'b1;
               end
            end
            DONE: begin
               if (!bus.if_read) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_rd_en = issue;
   assign bus.mem_addr  = issue ? (row_base_q + ADDR_W'(col_q)) : '0;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_valid ? head[DATA_W-1:0] : '0;
   assign bus.out_last  = out_valid && head[DATA_W];
   assign bus.if_done   = if_done_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: table of tiles, hand-written corner sequences
// and random tiles, all scored against an address/beat list computed from tile geometry.
module tb_if_fetch_unit;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 64;
   localparam int unsigned NW = 8;

   typedef struct {
      logic [AW-1:0] base;
      logic [NW-1:0] width;
      logic [NW-1:0] height;
      logic [AW-1:0] pitch;
      int            ready_mode;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
      int            abort_n;      // drop if_read after this many reads (0: never)
      int            hold_n;       // cycles to keep if_read high with clr_if after done
      int            exp_reads;
      logic [AW-1:0] exp_last_addr;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   if_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(NW)) bus ();

   if_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [AW-1:0] exp_addr_q [$];
   logic [AW-1:0] exp_beat_q [$];
   int            issued, popped, reads_seen, beats_seen, done_seen;
   int            done_cyc, last_hs_cyc, first_valid_cyc;
   logic [AW-1:0] last_rd_addr;
   logic          rd_pend = 1'b0;
   logic [AW-1:0] rd_pend_addr = '0;
   logic          s_rd, s_valid, s_last, s_done;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_data;

   vec_t vecs [10];

   function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
      return {a ^ 16'hA5C3, ~a, a + 16'h1357, a};
   endfunction

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic next_ready(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return ((k % 4) == 0) || ((k % 4) == 3);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Reference model: the tile as a list of addresses in row-major order.
   task automatic build_exp(input vec_t v);
      logic [AW-1:0] rb;
      exp_addr_q.delete();
      exp_beat_q.delete();
      rb = v.base;
      for (int r = 0; r < int'(v.height); r++) begin
         for (int c = 0; c < int'(v.width); c++) begin
            exp_addr_q.push_back(rb + AW'(c));
            exp_beat_q.push_back(rb + AW'(c));
         end
         rb = rb + v.pitch;
      end
      issued = 0; popped = 0; reads_seen = 0; beats_seen = 0; done_seen = 0;
      done_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1; last_rd_addr = '0;
   endtask

   // One clock cycle: present the SRAM return, sample outputs, score them, advance.
   task automatic observe(input bit ign_rd);
      logic [AW-1:0] a;
      bus.mem_rdata = rd_pend ? hash(rd_pend_addr) : {$urandom, $urandom};
      rd_pend = 1'b0;
      #1;
      s_rd = bus.mem_rd_en; s_addr = bus.mem_addr; s_valid = bus.out_valid;
      s_data = bus.out_data; s_last = bus.out_last; s_done = bus.if_done;
      if (s_rd === 1'b1) begin
         rd_pend = 1'b1;
         rd_pend_addr = s_addr;
         if (!ign_rd) begin
            reads_seen++; issued++; last_rd_addr = s_addr;
            if (exp_addr_q.size() == 0) check("extra_read", 64'(s_addr), 64'hDEAD);
            else check("rd_addr", 64'(s_addr), 64'(exp_addr_q.pop_front()));
         end
      end
      if (s_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (s_valid === 1'b1 && bus.out_ready === 1'b1) begin
         popped++; beats_seen++; last_hs_cyc = cyc;
         if (exp_beat_q.size() == 0) begin
            check("extra_beat", s_data, 64'hDEAD);
         end else begin
            a = exp_beat_q.pop_front();
            check("beat_data", s_data, hash(a));
            check("beat_last", 64'(s_last), 64'(exp_beat_q.size() == 0));
         end
      end
      if (s_last === 1'b1 && s_valid !== 1'b1) check("last_no_valid", 64'(s_valid), 64'd1);
      if (s_done === 1'b1) begin done_seen++; done_cyc = cyc; end
      if (s_rd === 1'b1 && !ign_rd) check("outstanding_le2", 64'(issued - popped <= 2), 64'd1);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bus.if_read = 1'b0;
         bus.clr_if = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         observe(1'b0);
         check("idle_quiet", {61'd0, s_rd, s_valid, s_done}, 64'd0);
      end
   endtask

   task automatic run_tile(input vec_t v);
      int c0, k;
      bit aborted;
      build_exp(v);
      bus.cfg_base = v.base; bus.cfg_width = v.width;
      bus.cfg_height = v.height; bus.cfg_pitch = v.pitch;
      bus.if_read = 1'b1; bus.clr_if = 1'b1;
      bus.out_ready = next_ready(v.ready_mode, 0);
      c0 = cyc;
      observe(1'b0);
      k = 1;
      aborted = 1'b0;
      while (done_seen == 0 && !aborted && k < 3000) begin
         if (v.abort_n > 0 && reads_seen >= v.abort_n) begin
            bus.if_read = 1'b0;
            bus.clr_if = 1'($urandom_range(0, 1));
            observe(1'b1);
            aborted = 1'b1;
         end else begin
            bus.clr_if = 1'($urandom_range(0, 1));
            bus.out_ready = next_ready(v.ready_mode, k);
            observe(1'b0);
         end
         k++;
      end
      if (k >= 3000) check("timeout", 64'(k), 64'd0);
      check("reads", 64'(reads_seen), 64'(v.exp_reads));
      if (v.exp_reads > 0) check("last_addr", 64'(last_rd_addr), 64'(v.exp_last_addr));
      if (aborted) begin
         idle(3);
         check("abort_no_done", 64'(done_seen), 64'd0);
      end else begin
         check("beats", 64'(beats_seen), 64'(v.exp_reads));
         check("done_count", 64'(done_seen), 64'd1);
         if (v.exp_reads == 0) begin
            check("zero_done_lat", 64'(done_cyc - c0), 64'd1);
            check("zero_no_valid", 64'(first_valid_cyc), 64'(-1));
         end else begin
            check("done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);
         end
         if (v.ready_mode == 0 && v.exp_reads > 0) begin
            check("first_valid_lat", 64'(first_valid_cyc - c0), 64'd2);
            check("burst_len", 64'(last_hs_cyc - c0), 64'(v.exp_reads + 1));
         end
         // DONE holds while if_read stays high; a fresh clr_if is ignored there
         for (int i = 0; i < v.hold_n; i++) begin
            bus.if_read = 1'b1; bus.clr_if = 1'b1;
            observe(1'b0);
            check("done_hold_quiet", {61'd0, s_rd, s_valid, s_done}, 64'd0);
         end
         bus.if_read = 1'b0;
         observe(1'b0);
         check("done_pulse_1cyc", 64'(s_done), 64'd0);
         idle(2);
      end
   endtask

   initial begin
      vec_t v;
      int n;
      vecs[0] = '{16'h0100, 8'd4, 8'd3, 16'h0010, 0, 0, 0, 12, 16'h0123};
      vecs[1] = '{16'h0100, 8'd4, 8'd3, 16'h0010, 1, 0, 0, 12, 16'h0123};
      vecs[2] = '{16'h0000, 8'd0, 8'd5, 16'h0000, 0, 0, 0, 0,  16'h0000};
      vecs[3] = '{16'hFFFE, 8'd4, 8'd1, 16'h0000, 0, 0, 0, 4,  16'h0001};
      vecs[4] = '{16'h0100, 8'd4, 8'd3, 16'h0010, 0, 5, 0, 5,  16'h0110};
      vecs[5] = '{16'h0100, 8'd4, 8'd3, 16'h0010, 2, 0, 0, 12, 16'h0123};
      vecs[6] = '{16'h0040, 8'd2, 8'd2, 16'h0008, 0, 0, 4, 4,  16'h0049};
      vecs[7] = '{16'h1234, 8'd1, 8'd1, 16'h0000, 1, 0, 0, 1,  16'h1234};
      vecs[8] = '{16'h0010, 8'd3, 8'd0, 16'h0005, 2, 0, 2, 0,  16'h0000};
      vecs[9] = '{16'hFFF0, 8'd3, 8'd3, 16'h0008, 2, 0, 0, 9,  16'h0002};

      bus.if_read = 1'b0; bus.clr_if = 1'b0; bus.out_ready = 1'b0;
      bus.cfg_base = '0; bus.cfg_width = '0; bus.cfg_height = '0; bus.cfg_pitch = '0;
      bus.mem_rdata = '0;
      build_exp(vecs[0]);
      exp_addr_q.delete();
      exp_beat_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (3) observe(1'b0);
      check("rst_rd_en", 64'(s_rd), 64'd0);
      check("rst_addr", 64'(s_addr), 64'd0);
      check("rst_valid", 64'(s_valid), 64'd0);
      check("rst_last", 64'(s_last), 64'd0);
      check("rst_data", s_data, 64'd0);
      check("rst_done", 64'(s_done), 64'd0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 10; i++) run_tile(vecs[i]);

      // Reset while draining with both skid entries occupied and the feeder stalled
      v = '{16'h0200, 8'd2, 8'd1, 16'h0000, 0, 0, 0, 2, 16'h0201};
      build_exp(v);
      bus.cfg_base = v.base; bus.cfg_width = v.width;
      bus.cfg_height = v.height; bus.cfg_pitch = v.pitch;
      bus.if_read = 1'b1; bus.clr_if = 1'b1; bus.out_ready = 1'b0;
      observe(1'b0);
      bus.clr_if = 1'b0;
      repeat (4) observe(1'b0);
      check("pre_rst_reads", 64'(reads_seen), 64'd2);
      check("pre_rst_valid", 64'(s_valid), 64'd1);
      rst = 1'b1;
      observe(1'b0);
      rst = 1'b0;
      bus.if_read = 1'b0;
      exp_addr_q.delete();
      exp_beat_q.delete();
      observe(1'b0);
      check("midrst_rd_en", 64'(s_rd), 64'd0);
      check("midrst_addr", 64'(s_addr), 64'd0);
      check("midrst_valid", 64'(s_valid), 64'd0);
      check("midrst_last", 64'(s_last), 64'd0);
      check("midrst_data", s_data, 64'd0);
      check("midrst_done", 64'(s_done), 64'd0);
      idle(1);
      run_tile(vecs[0]);

      // Random tiles, expectations from the geometry model
      for (int t = 0; t < 40; t++) begin
         v.base = AW'($urandom);
         v.pitch = AW'($urandom);
         v.width = NW'($urandom_range(0, 5));
         v.height = NW'($urandom_range(0, 4));
         v.ready_mode = 2;
         v.hold_n = int'($urandom_range(0, 2));
         n = int'(v.width) * int'(v.height);
         v.abort_n = (n > 1 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, n - 1)) : 0;
         v.exp_reads = (v.abort_n > 0) ? v.abort_n : n;
         build_exp(v);
         v.exp_last_addr = (v.exp_reads > 0) ? exp_addr_q[v.exp_reads - 1] : '0;
         run_tile(v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Responder side of the input-feature fetch handshake: consumes if_read/clr_if from the IF controller and returns if_done.
- Walks one input-feature tile in feature SRAM (row-major, programmable base/width/height/pitch).
- Issues single-cycle reads and streams the returned words to the systolic-array feeder over a valid/ready interface.
- Absorbs downstream stalls in a 2-entry skid buffer.

Parameters:
ADDR_W, 16, SRAM word-address width
DATA_W, 64, SRAM word / output beat width
DIM_W, 8, width of tile width/height counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_read  in  1  fetch request from IF controller; high for whole operation
clr_if  in  1  start qualifier; meaningful only when if_read=1 (may be X otherwise)
if_done  out  1  one-cycle pulse: tile fully delivered downstream
cfg_base  in  ADDR_W  tile start address
cfg_width  in  DIM_W  words per row
cfg_height  in  DIM_W  rows per tile
cfg_pitch  in  ADDR_W  address stride between rows
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM read address
mem_rdata  in  DATA_W  SRAM data, valid exactly 1 cycle after mem_rd_en
out_valid  out  1  beat valid to feeder
out_data  out  DATA_W  beat data
out_last  out  1  marks final beat of tile
out_ready  in  1  feeder accepts beat

Behaviour:
- Reset: state=IDLE; if_done=0, mem_rd_en=0, mem_addr=0, out_valid=0, out_last=0, out_data=0. Skid buffer empty, in-flight flag cleared, counters zeroed.
- State machine: IDLE, FETCH, DRAIN, DONE.
- IDLE: if_read=1 && clr_if=1 -> latch cfg_* into shadow registers; col=0, row=0, row_base=cfg_base; go FETCH.
  - Zero-size tile (width=0 or height=0) -> DONE instead, with if_done pulsed on the following cycle; no reads issued.
  - if_read=1 && clr_if=0 in IDLE -> ignored.
- FETCH: read issued in a cycle iff (buffer occupancy + in-flight) < 2.
  - Issue: mem_rd_en=1, mem_addr=row_base+col (mod 2^ADDR_W).
  - After issue: col++. At col==width-1 -> col=0, row++, row_base+=pitch (mod 2^ADDR_W).
  - Last read (row==height-1, col==width-1) -> go DRAIN; its in-flight beat is tagged last.
  - mem_rd_en and mem_addr are combinational from registered state; mem_rd_en is never high outside FETCH.
- Return path: the cycle after an issue, mem_rdata (plus last tag) is written into the skid buffer.
  - out_data/out_valid/out_last come from the buffer head.
  - Beat pops on out_valid && out_ready.
  - Simultaneous push and pop is legal; occupancy unchanged.
  - Buffer never overflows by construction. Overflow is an assertion failure.
  - Beats are delivered in issue order, with no duplication or loss under any out_ready pattern.
- DRAIN: wait until last beat pops -> if_done=1 for exactly that next cycle; go DONE.
- DONE: stay until if_read=0, then go IDLE. A new clr_if is not accepted until if_read has dropped.
  - The controller drops if_read the cycle after sampling if_done.
- Abort: if_read=0 in FETCH or DRAIN -> go IDLE next cycle.
  - Flush buffer; drop any in-flight return; if_done not pulsed; out_valid=0 from that next cycle.
- Reset mid-operation behaves exactly as the reset values above, including discarding the in-flight read.
- Throughput: with out_ready held 1, one beat per cycle.
  - First out_valid is 2 cycles after the clr_if cycle.
  - if_done is 1 cycle after the last handshake.
- out_last is high only with the final beat's out_valid.

Decomposition:
- Package if_pkg: fetch state enum (IDLE/FETCH/DRAIN/DONE), default ADDR_W/DATA_W/DIM_W constants, and a packed tile-config struct (base, width, height, pitch).
- Sub-module if_skid_buf: 2-entry FIFO carrying {last, data} with push/pop/occupancy. Keeps credit logic in the parent.

Test Plan:
- base=0x0100, width=4, height=3, pitch=0x0010, out_ready=1 -> addresses 0x100..0x103, 0x110..0x113, 0x120..0x123. 12 beats back-to-back; out_last on beat 12; if_done 1 cycle later.
- Same tile with out_ready toggling 1,0,0,1 repeating -> identical data order, no drops or duplicates. mem_rd_en stalls once 2 are outstanding; in-flight+occupancy never exceeds 2.
- width=0, height=5 -> no mem_rd_en; if_done pulses 1 cycle after the clr_if cycle; no out_valid.
- base=0xFFFE, width=4, height=1, pitch=0 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- if_read dropped after 5 reads of a 4x3 tile -> IDLE next cycle, out_valid=0, no if_done. A fresh clr_if then replays the full tile from row 0.
- rst asserted during DRAIN with 2 beats buffered -> all outputs at reset values next cycle. if_done held in DONE until if_read falls; clr_if while if_read stays high is ignored.
